// File: rtl/axi_helper.sv
// axi_helper: shared AXI4-Lite response codes, FSM state enums and LFSR constants.
package axi_helper;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/axil_sub_mem.sv
// axil_sub_mem: MEM_DEPTH x DATA_W byte-strobed register memory with a registered read port.
// Ports: clk, rst_n (async active-low, clears rdata only);
//        write port we/windex/wdata/wstrb; read port re/rindex -> rdata (old value on same-edge write).
module axil_sub_mem #(
  parameter int DATA_W = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int IDX_W = $clog2(MEM_DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  windex,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  rindex,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < STRB_W; i++)
        if (wstrb[i]) mem[windex][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[rindex];
endmodule

// File: rtl/axil_subordinate.sv
// axil_subordinate: AXI4-Lite subordinate holding a word-addressed, byte-strobed register memory.
// Ports: ACLK, ARESETn (async active-low); AW/W/B write channels; AR/R read channels.
// Optional: define AXIL_SUB_BACKPRESSURE_EN to gate AWREADY/WREADY/ARREADY with an LFSR bit.
module axil_subordinate
  import axi_helper::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W+2] == '0;
  endfunction

  wr_state_t wstate;
  rd_state_t rstate;
  logic aw_rdy, w_rdy, ar_rdy, gate;
  logic aw_got, w_got, aw_in_q, rd_oor;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DATA_W-1:0] wdata_q, mem_rdata;
  logic [STRB_W-1:0] wstrb_q;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

`ifdef AXIL_SUB_BACKPRESSURE_EN
  logic [7:0] lfsr;
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  assign gate = lfsr[0];
`else
  assign gate = 1'b1;
`endif

  assign AWREADY = aw_rdy & gate;
  assign WREADY = w_rdy & gate;
  assign ARREADY = ar_rdy & gate;

  logic aw_hs, w_hs, ar_hs, aw_got_n, w_got_n, w_fire, w_in;
  logic [IDX_W-1:0] w_idx;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign aw_got_n = aw_got | aw_hs;
  assign w_got_n = w_got | w_hs;
  // Commit on the edge where the second of AW/W completes (or both together)
  assign w_fire = (wstate == W_IDLE) & aw_got_n & w_got_n;
  assign w_idx = aw_got ? aw_idx_q : AWADDR[IDX_W+1:2];
  assign w_in = aw_got ? aw_in_q : in_range(AWADDR);

  axil_sub_mem #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk(ACLK),
    .rst_n(ARESETn),
    .we(w_fire & w_in),
    .windex(w_idx),
    .wdata(w_got ? wdata_q : WDATA),
    .wstrb(w_got ? wstrb_q : WSTRB),
    .re(ar_hs),
    .rindex(ARADDR[IDX_W+1:2]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      wstate <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_rdy <= 1'b0;
      w_rdy <= 1'b0;
      BVALID <= 1'b0;
      BRESP <= RESP_OKAY;
      aw_idx_q <= '0;
      aw_in_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (wstate == W_IDLE) begin
      if (aw_hs) begin
        aw_idx_q <= AWADDR[IDX_W+1:2];
        aw_in_q <= in_range(AWADDR);
      end
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      aw_got <= aw_got_n;
      w_got <= w_got_n;
      aw_rdy <= ~aw_got_n;
      w_rdy <= ~w_got_n;
      if (w_fire) begin
        wstate <= W_RESP;
        BVALID <= 1'b1;
        BRESP <= w_in ? RESP_OKAY : RESP_SLVERR;
      end
    end else if (BREADY) begin
      wstate <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_rdy <= 1'b1;
      w_rdy <= 1'b1;
      BVALID <= 1'b0;
    end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      rstate <= R_IDLE;
      ar_rdy <= 1'b0;
      RVALID <= 1'b0;
      RRESP <= RESP_OKAY;
      rd_oor <= 1'b0;
    end else if (rstate == R_IDLE) begin
      if (ar_hs) begin
        rstate <= R_RESP;
        ar_rdy <= 1'b0;
        RVALID <= 1'b1;
        rd_oor <= ~in_range(ARADDR);
        RRESP <= in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
      end else ar_rdy <= 1'b1;
    end else if (RREADY) begin
      rstate <= R_IDLE;
      ar_rdy <= 1'b1;
      RVALID <= 1'b0;
    end

  // Out-of-range reads return zero regardless of the aliased memory word
  assign RDATA = rd_oor ? '0 : mem_rdata;
endmodule

// File: doc/axil_subordinate.md
Name: axil_subordinate

Overview:
- AXI4-Lite subordinate: the downstream consumer of the manager's AW/W/B/AR/R channels on the shared axi4 interface.
- Holds a word-addressed, byte-strobed register memory.
- Independent write and read FSMs; one outstanding transaction per direction.
- Drives the bus target the manager bench exercises end to end.

Parameters:
- ADDR_W, 32, address width (matches bus ADDR_W)
- DATA_W, 32, data width (matches bus DATA_W); STRB_W = DATA_W/8 derived, not overridable
- MEM_DEPTH, 1024, number of DATA_W words; must be a power of two

Ports:
- ACLK  in  1  bus clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWADDR  in  ADDR_W  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_W  write data
- WSTRB  in  STRB_W  write byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_W  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response
- RVALID  out  1  read valid
- RREADY  in  1  read ready

Behaviour:
- Reset (async assert, sync release): all outputs 0; both FSMs go to IDLE; capture flags are cleared. Memory contents are not reset.
- Readies are registered and rise on the first edge after ARESETn deasserts.
- Address decode: word index = ADDR[log2(MEM_DEPTH)+1:2]; ADDR[1:0] is ignored. In range means ADDR >> 2 < MEM_DEPTH. Any upper bit set is out of range.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: AWREADY = ~aw_got, WREADY = ~w_got. AW and W are accepted independently, in either order or in the same cycle. Each handshake latches its payload and sets its flag; the corresponding ready drops the next cycle.
  - W_IDLE -> W_RESP on the edge where both flags are set (or both are completing this cycle). On that edge the memory commits WDATA per WSTRB byte lane, BVALID = 1, and BRESP = OKAY (2'b00), or SLVERR (2'b10) with the write dropped if out of range.
  - W_RESP: BVALID and BRESP are held stable until BVALID & BREADY. Then -> W_IDLE: flags clear, BVALID = 0, readies reassert the next cycle.
  - Latency: last of AW/W handshake at cycle N -> BVALID at cycle N+1. If BREADY is already high, the next AW is accepted at N+2 at earliest.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: ARREADY = 1.
  - On AR handshake at cycle N: RDATA is registered from the memory at that edge, RVALID = 1 at N+1, RRESP = OKAY. Out of range gives RDATA = 0 and RRESP = SLVERR.
  - R_RESP: ARREADY = 0; RDATA and RRESP are held until RVALID & RREADY, then -> R_IDLE.
- Simultaneous read and write to the same word: a write commit and an AR handshake on the same edge return the OLD data. A read handshaked on any later edge sees the new data.
- WSTRB = 0: a legal no-op write with BRESP OKAY.
- Payload or VALID changes while VALID is high and READY is low are protocol violations. The block does not check them.
- Reset mid-transaction: pending capture and response are discarded; no partial memory write occurs.

Optional Feature:
- Macro: AXIL_SUB_BACKPRESSURE_EN.
- Defined:
  - An 8-bit LFSR with taps 8,6,5,4 and seed 8'hA5 on reset advances every cycle.
  - AWREADY, WREADY and ARREADY are additionally ANDed with lfsr[0]. This gives pseudo-random stalls for handshake verification.
  - Response channels are unaffected.
- Undefined: no LFSR; readies are as described above, and throughput is one write per 2 cycles and one read per 2 cycles.

Decomposition:
- Shared package axi_helper gains:
  - resp_t constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_RESP}
  - the LFSR seed and taps constants
- One sub-module, axil_sub_mem: MEM_DEPTH x DATA_W array.
  - Write port: we, windex, wdata, wstrb.
  - Read port: registered rdata, sampling the old value on a same-edge conflict.
  - Instantiated once.

Test Plan:
- Write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF, then read ARADDR=0x10 -> BRESP=00 one cycle after the last handshake; RDATA=0xDEADBEEF, RRESP=00 one cycle after AR.
- Present W three cycles before AW (0x20, 0x12345678), then overwrite with WSTRB=4'b0010 and WDATA=0x0000AB00 -> readback 0x1234AB78.
- Write to AWADDR=0x1000 (index 1024, out of range) -> BRESP=10, no memory change; read 0x1000 -> RDATA=0, RRESP=10.
- Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID, RVALID and their payloads stay stable, AWREADY/WREADY/ARREADY stay 0; release -> next transaction is accepted.
- Same-edge write commit to 0x30 (old 0x1, new 0x2) with AR to 0x30 -> RDATA=0x1; a following read returns 0x2.
- Assert ARESETn low while in W_RESP with BVALID=1 -> all outputs 0 immediately; after release a read of that address returns the pre-existing value.
